// File: rtl/transfer_tx.sv
// transfer_tx -- transmit end of the scanner / transfer-center serial link.
//
// Serializes command bytes and transfer payloads MSB-first on serial_out in
// fixed 8-cycle slots that free-run from reset release. There is no framing:
// the receiver counts 8 bits per byte from the same reset, and 0x00 is idle.
//
// Ports:
//   clk, rst             rising-edge clock, async active-low reset
//   fill_level           scan-buffer occupancy (0..DEPTH) -> status codes 1..4
//   flush_req            pulse, queue a Flush byte (0x05)
//   ready_query          pulse, queue a Ready? byte (0x06)
//   xfer_req             pulse, start a transfer; xfer_ascii/xfer_len sampled with it
//   data_in/data_valid   payload source; data_ready is the accept strobe
//   xfer_busy            transfer accepted and not finished
//   xfer_done            one-cycle pulse after the final transfer byte is loaded
//   xfer_err             sticky underrun flag, cleared by the next accepted xfer_req
//   serial_out           registered serial line (shift register MSB)
module transfer_tx #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] fill_level,
  input  logic             flush_req,
  input  logic             ready_query,
  input  logic             xfer_req,
  input  logic             xfer_ascii,
  input  logic [7:0]       xfer_len,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             xfer_busy,
  output logic             xfer_done,
  output logic             xfer_err,
  output logic             serial_out
);

  localparam int WW = CNT_W + 4;
  localparam logic [WW-1:0] TH90 = WW'(9 * DEPTH);
  localparam logic [WW-1:0] TH80 = WW'(8 * DEPTH);
  localparam logic [WW-1:0] THD  = WW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_DATA} state_t;

  state_t      r_state, w_state_nx;
  logic [7:0]  r_shreg;
  logic [2:0]  r_bit_cnt;
  logic        r_stat_pend, r_flush_pend, r_query_pend, r_xfer_pend;
  logic [2:0]  r_last_lvl;
  logic        r_busy, r_ascii, r_done, r_err;
  logic [7:0]  r_len, r_remain, r_fetch, r_hold;
  logic        r_hold_valid;

  logic [WW-1:0] w_f;
  logic [2:0]    w_lvl;
  logic          w_lvl_up, w_load, w_accept, w_take;
  logic [7:0]    w_next_byte;
  logic          w_send_stat, w_send_flush, w_send_query, w_send_hdr, w_send_data, w_fin;

  assign w_load     = (r_bit_cnt == 3'd7);
  assign w_accept   = xfer_req & ~r_busy;
  assign data_ready = r_busy & ~r_hold_valid & (r_fetch < r_len);
  assign w_take     = data_valid & data_ready;

  assign serial_out = r_shreg[7];
  assign xfer_busy  = r_busy;
  assign xfer_done  = r_done;
  assign xfer_err   = r_err;

  // Fill level thresholds; products widened so 10*DEPTH cannot overflow.
  assign w_f = WW'(fill_level);
  always_comb begin
    w_lvl = 3'd0;
    if (fill_level == CNT_W'(DEPTH))     w_lvl = 3'd4;
    else if (w_f * WW'(10) >= TH90)      w_lvl = 3'd3;
    else if (w_f * WW'(10) >= TH80)      w_lvl = 3'd2;
    else if (w_f * WW'(2)  >= THD)       w_lvl = 3'd1;
  end
  assign w_lvl_up = (w_lvl > r_last_lvl);

  // Byte selection for the next slot load. Status is only sent if the level
  // is still above the last reported one at load time, so a level that fell
  // back while waiting behind a transfer is dropped rather than sent stale.
  always_comb begin
    w_state_nx   = r_state;
    w_next_byte  = 8'h00;
    w_send_stat  = 1'b0;
    w_send_flush = 1'b0;
    w_send_query = 1'b0;
    w_send_hdr   = 1'b0;
    w_send_data  = 1'b0;
    w_fin        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_stat_pend && w_lvl_up) begin
          w_send_stat = 1'b1;
          w_next_byte = {5'd0, w_lvl};
        end else if (r_flush_pend) begin
          w_send_flush = 1'b1;
          w_next_byte  = 8'h05;
        end else if (r_query_pend) begin
          w_send_query = 1'b1;
          w_next_byte  = 8'h06;
        end else if (r_xfer_pend) begin
          w_send_hdr  = 1'b1;
          w_next_byte = r_ascii ? 8'h08 : 8'h07;
          w_state_nx  = ST_LEN;
        end
      end
      ST_LEN: begin
        w_next_byte = r_len;
        if (r_len == 8'd0) begin
          w_fin      = 1'b1;
          w_state_nx = ST_IDLE;
        end else begin
          w_state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        w_send_data = 1'b1;
        w_next_byte = r_hold_valid ? r_hold : 8'h00;  // underrun sends filler
        if (r_remain == 8'd1) begin
          w_fin      = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_state <= ST_IDLE;
    else if (w_load) r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_stat_pend  <= 1'b0;
      r_flush_pend <= 1'b0;
      r_query_pend <= 1'b0;
      r_xfer_pend  <= 1'b0;
      r_last_lvl   <= 3'd0;
      r_busy       <= 1'b0;
      r_ascii      <= 1'b0;
      r_len        <= 8'd0;
      r_remain     <= 8'd0;
      r_fetch      <= 8'd0;
      r_hold       <= 8'd0;
      r_hold_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_load) begin
        r_shreg   <= w_next_byte;
        r_bit_cnt <= 3'd0;
      end else begin
        r_shreg   <= {r_shreg[6:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      // A repeat pulse landing on the load edge of its own byte merges into it.
      r_flush_pend <= (r_flush_pend | flush_req)   & ~(w_load & w_send_flush);
      r_query_pend <= (r_query_pend | ready_query) & ~(w_load & w_send_query);

      if (w_load) begin
        r_stat_pend <= w_lvl_up & ~w_send_stat;
        // Falling below the last report re-arms that level without a byte.
        if (w_send_stat || (w_lvl < r_last_lvl)) r_last_lvl <= w_lvl;
        if (w_send_hdr) r_xfer_pend <= 1'b0;
        if (r_state == ST_LEN) r_remain <= r_len;
        if (w_send_data) begin
          r_remain <= r_remain - 8'd1;
          if (!r_hold_valid) r_err <= 1'b1;
        end
        if (w_fin) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end

      if (w_accept) begin
        r_busy      <= 1'b1;
        r_xfer_pend <= 1'b1;
        r_ascii     <= xfer_ascii;
        r_len       <= xfer_len;
        r_fetch     <= 8'd0;
        r_err       <= 1'b0;
      end

      if (w_take) begin
        r_hold       <= data_in;
        r_hold_valid <= 1'b1;
        r_fetch      <= r_fetch + 8'd1;
      end else if (w_load && w_send_data) begin
        r_hold_valid <= 1'b0;
      end
      // A byte fetched late after an underrun is never sent; drop it at the end.
      if (w_load && w_fin) r_hold_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_transfer_tx.sv
module tb_transfer_tx;
  localparam int DEPTH = 256;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] fill_level = '0;
  logic             flush_req = 1'b0, ready_query = 1'b0, xfer_req = 1'b0, xfer_ascii = 1'b0;
  logic [7:0]       xfer_len = 8'd0, data_in = 8'd0;
  logic             data_valid = 1'b0;
  logic             data_ready, xfer_busy, xfer_done, xfer_err, serial_out;

  always #5 clk = ~clk;

  transfer_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fill_level(fill_level), .flush_req(flush_req),
    .ready_query(ready_query), .xfer_req(xfer_req), .xfer_ascii(xfer_ascii),
    .xfer_len(xfer_len), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .xfer_busy(xfer_busy), .xfer_done(xfer_done),
    .xfer_err(xfer_err), .serial_out(serial_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc;          // rising edges since reset release

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  // Receiver: rebuild slot bytes from the line, MSB first, 8 bits per slot.
  logic [7:0] acc;
  logic [7:0] rx_q[$];
  int         done_q[$];
  always @(negedge clk) begin
    if (!rst) acc = 8'h00;
    else if (cyc > 0) begin
      acc = {acc[6:0], serial_out};
      if (cyc % 8 == 7) rx_q.push_back(acc);
      if (xfer_done) done_q.push_back(cyc);
    end
  end

  // Payload source: offers the queue head whenever allowed.
  logic [7:0] src_q[$];
  bit         src_hold = 1'b0;
  always @(negedge clk) begin
    if (rst && !src_hold && src_q.size() > 0) begin
      data_valid = 1'b1;
      data_in    = src_q[0];
      if (data_ready) void'(src_q.pop_front());
    end else begin
      data_valid = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] slot(input int k);
    return (rx_q.size() > k) ? rx_q[k] : 8'hEE;
  endfunction

  // Wait (at negedges) until the next rising edge is number c.
  task automatic goto(input int c);
    while (cyc < c - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush_req = 0; ready_query = 0; xfer_req = 0; xfer_ascii = 0; xfer_len = 0;
    fill_level = '0;
    src_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_serial", serial_out, 0);
    chk("rst_ready",  data_ready, 0);
    chk("rst_busy",   xfer_busy,  0);
    chk("rst_done",   xfer_done,  0);
    chk("rst_err",    xfer_err,   0);
    rx_q.delete(); src_q.delete(); done_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pulse_flush(input int c);
    goto(c); flush_req = 1'b1; @(negedge clk); flush_req = 1'b0;
  endtask

  task automatic pulse_query(input int c);
    goto(c); ready_query = 1'b1; @(negedge clk); ready_query = 1'b0;
  endtask

  task automatic do_xfer(input int c, input bit ascii, input logic [7:0] len);
    goto(c);
    xfer_req = 1'b1; xfer_ascii = ascii; xfer_len = len;
    @(negedge clk);
    xfer_req = 1'b0;
  endtask

  // Reference: occupancy fraction thresholds.
  function automatic int lvl_of(input int f);
    real r;
    r = real'(f) / real'(DEPTH);
    if (f == DEPTH) return 4;
    if (r >= 0.9)   return 3;
    if (r >= 0.8)   return 2;
    if (r >= 0.5)   return 1;
    return 0;
  endfunction

  typedef struct { int fill; logic [7:0] code; } lvl_vec_t;
  lvl_vec_t tbl[9];

  int         picks[13] = '{0, 64, 127, 128, 150, 204, 205, 220, 230, 231, 250, 255, 256};
  // reference model state for the random phase
  int         m_last;
  bit         m_spend, m_fp, m_qp, m_busy, m_inx, m_done;
  logic [7:0] xq[$], exp_q[$], nz[$];

  initial begin
    tbl = '{'{0, 8'h00}, '{127, 8'h00}, '{128, 8'h01}, '{204, 8'h01}, '{205, 8'h02},
            '{230, 8'h02}, '{231, 8'h03}, '{255, 8'h03}, '{256, 8'h04}};

    // Idle line after reset.
    begin
      logic bad;
      do_reset();
      bad = 1'b0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        bad = bad | serial_out | data_ready | xfer_busy | xfer_done;
      end
      chk("idle_quiet", bad, 0);
    end

    // Level mapping: static fill from reset, code appears in slot 2.
    for (int i = 0; i < 9; i++) begin
      int q;
      do_reset();
      fill_level = CNT_W'(tbl[i].fill);
      goto(36);
      chk($sformatf("lvl_code_f%0d", tbl[i].fill), slot(2), tbl[i].code);
      q = 0;
      for (int k = 0; k < 4; k++) if (k != 2 && slot(k) != 8'h00) q++;
      chk("lvl_quiet", q, 0);
    end

    // Flush in slot 2, query right after; async reset mid-byte discards work.
    do_reset();
    pulse_flush(20);
    pulse_query(21);
    goto(30);
    chk("flush_bit5", serial_out, 1);
    goto(36);
    chk("slot2_idle", slot(2), 8'h00);
    chk("flush_slot3", slot(3), 8'h05);
    pulse_flush(36);
    goto(38);
    chk("query_bit5", serial_out, 1);
    #2 rst = 1'b0;
    #1 chk("async_rst_line", serial_out, 0);
    do_reset();
    goto(36);
    begin
      int q = 0;
      for (int k = 0; k < 4; k++) if (slot(k) != 8'h00) q++;
      chk("rst_discards_pend", q, 0);
    end

    // Fill ramp: one code per level step, re-armed after dropping to 0.
    do_reset();
    goto(20);  fill_level = 9'd128;
    goto(44);  fill_level = 9'd205;
    goto(68);  fill_level = 9'd231;
    goto(92);  fill_level = 9'd0;
    goto(116); fill_level = 9'd256;
    goto(170);
    nz.delete();
    foreach (rx_q[k]) if (rx_q[k] != 8'h00) nz.push_back(rx_q[k]);
    chk("ramp_count", nz.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("ramp_code%0d", k), (nz.size() > k) ? nz[k] : 8'hEE, k + 1);

    // Binary transfer, len 2, source ready at once.
    do_reset();
    src_q.push_back(8'hA5); src_q.push_back(8'h3C);
    do_xfer(4, 1'b0, 8'd2);
    goto(50);
    chk("bin_hdr",  slot(1), 8'h07);
    chk("bin_len",  slot(2), 8'h02);
    chk("bin_d0",   slot(3), 8'hA5);
    chk("bin_d1",   slot(4), 8'h3C);
    chk("bin_tail", slot(5), 8'h00);
    chk("bin_done_n",   done_q.size(), 1);
    chk("bin_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 32);
    chk("bin_err",  xfer_err, 0);
    chk("bin_busy", xfer_busy, 0);

    // ASCII transfer, len 3, second byte withheld past its slot.
    do_reset();
    src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
    do_xfer(4, 1'b1, 8'd3);
    goto(10); src_hold = 1'b1;
    goto(36); src_hold = 1'b0;
    goto(50);
    chk("asc_hdr", slot(1), 8'h08);
    chk("asc_len", slot(2), 8'h03);
    chk("asc_d0",  slot(3), 8'h11);
    chk("asc_ur",  slot(4), 8'h00);
    chk("asc_d1",  slot(5), 8'h22);
    chk("asc_err", xfer_err, 1);
    chk("asc_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 40);
    do_xfer(52, 1'b0, 8'd0);
    chk("err_clear_on_accept", xfer_err, 0);
    chk("busy_on_accept", xfer_busy, 1);

    // Level crossing and query during a len 1 transfer; xfer_req while busy.
    do_reset();
    src_q.push_back(8'h5A);
    do_xfer(4, 1'b0, 8'd1);
    goto(10); fill_level = 9'd130;
    pulse_query(12);
    do_xfer(14, 1'b1, 8'd9);
    goto(60);
    chk("mix_hdr",  slot(1), 8'h07);
    chk("mix_len",  slot(2), 8'h01);
    chk("mix_d0",   slot(3), 8'h5A);
    chk("mix_stat", slot(4), 8'h01);
    chk("mix_qry",  slot(5), 8'h06);
    chk("mix_ignored_req", slot(6), 8'h00);
    chk("mix_busy", xfer_busy, 0);
    chk("mix_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 24);

    // Randomized traffic against a slot-level queue model.
    do_reset();
    m_last = 0; m_spend = 0; m_fp = 0; m_qp = 0; m_busy = 0; m_inx = 0; m_done = 0;
    xq.delete(); exp_q.delete();
    exp_q.push_back(8'h00);
    for (int c = 1; c <= 1200; c++) begin
      goto(c);
      chk("rnd_busy", xfer_busy, m_busy);
      chk("rnd_done", xfer_done, m_done);
      flush_req = 0; ready_query = 0; xfer_req = 0;
      if (c % 8 != 0) begin
        if ($urandom_range(40) == 0) flush_req = 1'b1;
        if ($urandom_range(40) == 0) ready_query = 1'b1;
        if ($urandom_range(25) == 0) begin
          xfer_req   = 1'b1;
          xfer_ascii = 1'($urandom_range(1));
          xfer_len   = 8'($urandom_range(4));
        end
      end
      if ($urandom_range(15) == 0) fill_level = CNT_W'(picks[$urandom_range(12)]);
      m_done = 0;
      if (c % 8 == 0) begin
        int L;
        logic [7:0] b;
        bit sent;
        L = lvl_of(int'(fill_level));
        sent = 0;
        if (m_inx) begin
          b = xq.pop_front();
          if (xq.size() == 0) begin m_inx = 0; m_busy = 0; m_done = 1; end
        end else if (m_spend && L > m_last) begin
          b = 8'(L); sent = 1;
        end else if (m_fp) begin
          b = 8'h05; m_fp = 0;
        end else if (m_qp) begin
          b = 8'h06; m_qp = 0;
        end else if (m_busy) begin
          b = xq.pop_front(); m_inx = 1;
        end else begin
          b = 8'h00;
        end
        m_spend = (L > m_last) && !sent;
        if (sent || L < m_last) m_last = L;
        exp_q.push_back(b);
      end else begin
        m_fp = m_fp | flush_req;
        m_qp = m_qp | ready_query;
        if (xfer_req && !m_busy) begin
          m_busy = 1;
          xq.push_back(xfer_ascii ? 8'h08 : 8'h07);
          xq.push_back(xfer_len);
          for (int j = 0; j < int'(xfer_len); j++) begin
            logic [7:0] p;
            p = 8'($urandom_range(255));
            xq.push_back(p);
            src_q.push_back(p);
          end
        end
      end
    end
    goto(1203);
    chk("rnd_slots_seen", rx_q.size() >= 140, 1);
    for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++)
      chk($sformatf("rnd_slot%0d", k), rx_q[k], exp_q[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
